// File: rtl/bb_mem_arbiter_pkg.sv
// Shared types and constants for the bb_core SRAM arbiter.
package bb_mem_arbiter_pkg;
   localparam int DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_ACCESS  = 2'd1,
      ARB_CAPTURE = 2'd2,
      ARB_ACK     = 2'd3
   } arb_state_t;

   // Bit positions within the one-hot {dma, core} grant vector.
   localparam int ARB_OWN_CORE = 0;
   localparam int ARB_OWN_DMA  = 1;
endpackage

// File: rtl/bb_arb_select.sv
// Fixed core-first priority with a starvation guard that forces dma through
// after STARVE_LIMIT core wins made while dma was waiting.
module bb_arb_select
   import bb_mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       core_req,
   input  logic       dma_req,
   input  logic       decide,
   output logic [1:0] win
);

   logic [3:0] starve_cnt;

   always_comb begin
      win = '0;
      if (decide) begin
         if (dma_req && starve_cnt == 4'(STARVE_LIMIT)) win[ARB_OWN_DMA]  = 1'b1;
         else if (core_req)                             win[ARB_OWN_CORE] = 1'b1;
         else if (dma_req)                              win[ARB_OWN_DMA]  = 1'b1;
      end
   end

   // Counts only decisions where dma was actually left waiting.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (decide) begin
         if (!dma_req || win[ARB_OWN_DMA])
            starve_cnt <= '0;
         else if (win[ARB_OWN_CORE] && starve_cnt != 4'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 4'd1;
      end
   end

endmodule

// File: rtl/bb_mem_arbiter.sv
// Serialises core and dma accesses onto one single-port synchronous SRAM
// with programmable wait states.
module bb_mem_arbiter
   import bb_mem_arbiter_pkg::*;
#(
   parameter int DW           = DATA_WIDTH,
   parameter int WAIT_STATES  = 1,
   parameter int STARVE_LIMIT = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_core_req,
   input  logic          i_core_wen,
   input  logic [DW-1:0] i_core_addr,
   input  logic [DW-1:0] i_core_data,
   output logic          o_core_ack,
   output logic [DW-1:0] o_core_data,
   input  logic          i_dma_req,
   input  logic          i_dma_wen,
   input  logic [DW-1:0] i_dma_addr,
   input  logic [DW-1:0] i_dma_data,
   output logic          o_dma_ack,
   output logic [DW-1:0] o_dma_data,
   output logic          o_sram_cen,
   output logic          o_sram_wen,
   output logic [DW-1:0] o_sram_addr,
   output logic [DW-1:0] o_sram_data,
   input  logic [DW-1:0] i_sram_data,
   output logic [1:0]    o_grant
);

   arb_state_t state;
   logic [2:0] wait_cnt;
   logic       owner_dma;
   logic       wen_q;
   logic [1:0] win;

   bb_arb_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_sel (
      .clk      (clk),
      .rst      (rst_n),
      .core_req (i_core_req),
      .dma_req  (i_dma_req),
      .decide   (state == ARB_IDLE),
      .win      (win)
   );

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state       <= ARB_IDLE;
         wait_cnt    <= '0;
         owner_dma   <= 1'b0;
         wen_q       <= 1'b0;
         o_sram_cen  <= 1'b0;
         o_sram_wen  <= 1'b0;
         o_sram_addr <= '0;
         o_sram_data <= '0;
         o_core_ack  <= 1'b0;
         o_dma_ack   <= 1'b0;
         o_core_data <= '0;
         o_dma_data  <= '0;
         o_grant     <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (|win) begin
                  owner_dma   <= win[ARB_OWN_DMA];
                  o_grant     <= win;
                  wen_q       <= win[ARB_OWN_DMA] ? i_dma_wen  : i_core_wen;
                  o_sram_wen  <= win[ARB_OWN_DMA] ? i_dma_wen  : i_core_wen;
                  o_sram_addr <= win[ARB_OWN_DMA] ? i_dma_addr : i_core_addr;
                  o_sram_data <= win[ARB_OWN_DMA] ? i_dma_data : i_core_data;
                  o_sram_cen  <= 1'b1;
                  wait_cnt    <= 3'(WAIT_STATES);
                  state       <= ARB_ACCESS;
               end
            end
            ARB_ACCESS: begin
               if (wait_cnt == 3'd0) begin
                  o_sram_cen <= 1'b0;
                  o_sram_wen <= 1'b0;
                  state      <= ARB_CAPTURE;
               end else begin
                  wait_cnt <= wait_cnt - 3'd1;
               end
            end
            ARB_CAPTURE: begin
               // SRAM read data is valid in the cycle after the last enable.
               if (!wen_q) begin
                  if (owner_dma) o_dma_data  <= i_sram_data;
                  else           o_core_data <= i_sram_data;
               end
               o_dma_ack  <= owner_dma;
               o_core_ack <= !owner_dma;
               state      <= ARB_ACK;
            end
            ARB_ACK: begin
               o_core_ack <= 1'b0;
               o_dma_ack  <= 1'b0;
               o_grant    <= '0;
               state      <= ARB_IDLE;
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bb_mem_arbiter.sv
// Directed bench for bb_mem_arbiter: main WAIT_STATES=1 instance plus
// WAIT_STATES=0/7 instances for latency checks.
module tb_bb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        core_req = 0, core_wen = 0, dma_req = 0, dma_wen = 0;
   logic [31:0] core_addr = '0, core_wdata = '0, dma_addr = '0, dma_wdata = '0;
   logic        core_ack, dma_ack, sram_cen, sram_wen;
   logic [31:0] core_rdata, dma_rdata, sram_addr, sram_wdata, sram_rdata;
   logic [1:0]  grant;

   logic        req0 = 0, req7 = 0;
   logic        ack0, ack7, cen0, cen7, dack0, dack7, wen0, wen7;
   logic [31:0] rd0, rd7, drd0, drd7, a0, a7, d0, d7;
   logic [1:0]  g0, g7;

   int n_tests = 0, n_fail = 0;
   int viol = 0, bad_grant = 0, bad_starve = 0;
   logic mon_on = 1'b0;

   always #5 clk = ~clk;

   bb_mem_arbiter #(.WAIT_STATES(1), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst_n(rst),
      .i_core_req(core_req), .i_core_wen(core_wen), .i_core_addr(core_addr), .i_core_data(core_wdata),
      .o_core_ack(core_ack), .o_core_data(core_rdata),
      .i_dma_req(dma_req), .i_dma_wen(dma_wen), .i_dma_addr(dma_addr), .i_dma_data(dma_wdata),
      .o_dma_ack(dma_ack), .o_dma_data(dma_rdata),
      .o_sram_cen(sram_cen), .o_sram_wen(sram_wen), .o_sram_addr(sram_addr), .o_sram_data(sram_wdata),
      .i_sram_data(sram_rdata), .o_grant(grant)
   );

   bb_mem_arbiter #(.WAIT_STATES(0)) dut0 (
      .clk(clk), .rst_n(rst),
      .i_core_req(req0), .i_core_wen(1'b0), .i_core_addr(32'h44), .i_core_data(32'h0),
      .o_core_ack(ack0), .o_core_data(rd0),
      .i_dma_req(1'b0), .i_dma_wen(1'b0), .i_dma_addr(32'h0), .i_dma_data(32'h0),
      .o_dma_ack(dack0), .o_dma_data(drd0),
      .o_sram_cen(cen0), .o_sram_wen(wen0), .o_sram_addr(a0), .o_sram_data(d0),
      .i_sram_data(32'hCAFE_0000), .o_grant(g0)
   );

   bb_mem_arbiter #(.WAIT_STATES(7)) dut7 (
      .clk(clk), .rst_n(rst),
      .i_core_req(req7), .i_core_wen(1'b0), .i_core_addr(32'h44), .i_core_data(32'h0),
      .o_core_ack(ack7), .o_core_data(rd7),
      .i_dma_req(1'b0), .i_dma_wen(1'b0), .i_dma_addr(32'h0), .i_dma_data(32'h0),
      .o_dma_ack(dack7), .o_dma_data(drd7),
      .o_sram_cen(cen7), .o_sram_wen(wen7), .o_sram_addr(a7), .o_sram_data(d7),
      .i_sram_data(32'hCAFE_0007), .o_grant(g7)
   );

   // Synchronous single-port SRAM model
   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (sram_cen) begin
         if (sram_wen) mem[sram_addr[7:0]] <= sram_wdata;
         else          sram_rdata <= mem[sram_addr[7:0]];
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         if ((core_ack || dma_ack) && sram_cen) viol++;
         if (core_ack && dma_ack) viol++;
         if (mon_on && grant == 2'b10) bad_grant++;
         if (mon_on && dut.u_sel.starve_cnt != 4'd0) bad_starve++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Call just after a rising edge; cycle 0 is the IDLE cycle that samples the request.
   int ack_at, cf, cn, wn;
   logic [31:0] rd, ca;
   logic oa;
   logic [1:0] g1;

   task automatic access(input logic is_dma, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata);
      ack_at = -1; cf = -1; cn = 0; wn = 0; rd = '0; ca = '0; oa = 0; g1 = '0;
      if (is_dma) begin dma_req = 1; dma_wen = wen; dma_addr = addr; dma_wdata = wdata; end
      else begin core_req = 1; core_wen = wen; core_addr = addr; core_wdata = wdata; end
      for (int n = 0; n < 40 && ack_at < 0; n++) begin
         @(negedge clk);
         if (n == 1) begin
            // Drop the request and scramble inputs after the latch.
            g1 = grant;
            core_req = 0; dma_req = 0;
            core_addr = 32'hDEAD_00FF; dma_addr = 32'hDEAD_00FE;
            core_wdata = 32'h5555; dma_wdata = 32'h6666;
         end
         if (sram_cen) begin
            if (cf < 0) cf = n;
            cn++;
            if (sram_wen) wn++;
            ca = sram_addr;
         end
         if (is_dma ? dma_ack : core_ack) begin ack_at = n; rd = is_dma ? dma_rdata : core_rdata; end
         if (is_dma ? core_ack : dma_ack) oa = 1;
      end
      core_req = 0; dma_req = 0;
      @(posedge clk); #1;
   endtask

   task automatic probe(input int ws);
      logic c, a;
      ack_at = -1; cf = -1; cn = 0; rd = '0;
      if (ws == 0) req0 = 1; else req7 = 1;
      for (int n = 0; n < 40 && ack_at < 0; n++) begin
         @(negedge clk);
         c = (ws == 0) ? cen0 : cen7;
         a = (ws == 0) ? ack0 : ack7;
         if (c) begin if (cf < 0) cf = n; cn++; end
         if (a) begin ack_at = n; rd = (ws == 0) ? rd0 : rd7; end
      end
      req0 = 0; req7 = 0;
      @(posedge clk); #1;
   endtask

   initial begin
      int acks;
      logic [9:0] order;
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [9:0] order;
      int acks;

      // Reset state
      @(negedge clk);
      chk("rst_cen", {31'd0, sram_cen}, 0);
      chk("rst_grant", {30'd0, grant}, 0);
      chk("rst_acks", {30'd0, core_ack, dma_ack}, 0);
      chk("rst_core_data", core_rdata, 0);
      @(posedge clk); @(negedge clk);
      rst = 0;
      @(posedge clk); #1;

      // DMA write preload, then core read
      access(1, 1, 32'h10, 32'hBEEF);
      chk("dw_ack_cycle", ack_at, 4);
      chk("dw_wen_cycles", wn, 2);
      chk("dw_grant", {30'd0, g1}, 2'b10);
      access(0, 0, 32'h10, 32'h0);
      chk("cr_cen_first", cf, 1);
      chk("cr_cen_width", cn, 2);
      chk("cr_addr", ca, 32'h10);
      chk("cr_ack_cycle", ack_at, 4);
      chk("cr_data", rd, 32'hBEEF);
      chk("cr_no_dma_ack", {31'd0, oa}, 0);
      chk("cr_grant", {30'd0, g1}, 2'b01);
      repeat (3) @(posedge clk);
      #1 chk("cr_data_hold", core_rdata, 32'hBEEF);

      // DMA write 0x1234 @0x20, core reads it back
      access(1, 1, 32'h20, 32'h1234);
      chk("dw2_wen_cycles", wn, 2);
      chk("dw2_addr", ca, 32'h20);
      access(0, 0, 32'h20, 32'h0);
      chk("cr2_data", rd, 32'h1234);
      chk("cr2_wen_cycles", wn, 0);
      access(1, 0, 32'h10, 32'h0);
      chk("dr_data", rd, 32'hBEEF);
      chk("dr_core_untouched", core_rdata, 32'h1234);

      // Both ports requesting continuously
      core_wen = 0; dma_wen = 0; core_addr = 32'h10; dma_addr = 32'h20;
      core_req = 1; dma_req = 1;
      order = '0; acks = 0;
      for (int n = 0; n < 200 && acks < 10; n++) begin
         @(negedge clk);
         if (dma_ack) begin order[acks] = 1'b1; acks++; end
         else if (core_ack) begin acks++; end
      end
      core_req = 0; dma_req = 0;
      @(posedge clk); #1;
      chk("alt_acks", acks, 10);
      chk("alt_order", {22'd0, order}, 32'h210);
      chk("alt_core_data", core_rdata, 32'hBEEF);
      chk("alt_dma_data", dma_rdata, 32'h1234);

      // Core-only traffic
      mon_on = 1; acks = 0;
      for (int i = 0; i < 10; i++) begin
         access(0, 0, 32'h20, 32'h0);
         if (ack_at == 4) acks++;
      end
      mon_on = 0;
      chk("co_acks", acks, 10);
      chk("co_bad_grant", bad_grant, 0);
      chk("co_starve", bad_starve, 0);

      // Reset during a dma read ACCESS
      dma_req = 1; dma_wen = 0; dma_addr = 32'h20;
      @(negedge clk); @(negedge clk); @(negedge clk);
      chk("rr_cen_before", {31'd0, sram_cen}, 1);
      rst = 1; dma_req = 0;
      #1;
      chk("rr_cen", {31'd0, sram_cen}, 0);
      chk("rr_grant", {30'd0, grant}, 0);
      chk("rr_ack", {31'd0, dma_ack}, 0);
      chk("rr_core_data", core_rdata, 0);
      @(posedge clk); @(posedge clk); @(negedge clk);
      rst = 0;
      acks = 0;
      repeat (8) begin @(negedge clk); if (dma_ack || core_ack) acks++; end
      chk("rr_no_ack", acks, 0);
      @(posedge clk); #1;
      access(1, 0, 32'h20, 32'h0);
      chk("rr_reissue_ack", ack_at, 4);
      chk("rr_reissue_data", rd, 32'h1234);

      // Wait-state extremes
      probe(0);
      chk("ws0_ack", ack_at, 3);
      chk("ws0_cen_first", cf, 1);
      chk("ws0_cen_width", cn, 1);
      chk("ws0_data", rd, 32'hCAFE_0000);
      probe(7);
      chk("ws7_ack", ack_at, 10);
      chk("ws7_cen_width", cn, 8);
      chk("ws7_data", rd, 32'hCAFE_0007);

      chk("ack_cen_overlap", viol, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
